// File: rtl/dmem_responder.sv
// Single-outstanding load/store memory responder. A response appears WAIT_CYCLES+1 cycles after acceptance.
// The response is held unchanged until rsp_ready. Misaligned, oversize or illegal-size accesses fault and never write.
module dmem_responder #(
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wr,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_byt_en,
    input  logic        i_req_sign_ext,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [3:0]      WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [AW-1:0]   IDX1      = 1;
    localparam logic [AW-1:0]   IDX2      = 2;
    localparam logic [AW-1:0]   IDX3      = 3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_wait_cnt;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;
    logic [7:0]    r_mem [DEPTH];

    logic          w_accept;
    logic          w_is_byte;
    logic          w_is_half;
    logic          w_is_word;
    logic          w_err;
    logic [2:0]    w_nbytes;
    logic [32:0]   w_end;
    logic [AW-1:0] w_idx0;
    logic [AW-1:0] w_idx1;
    logic [AW-1:0] w_idx2;
    logic [AW-1:0] w_idx3;
    logic [31:0]   w_raw;
    logic [31:0]   w_ext;

    assign w_is_byte = (i_req_byt_en == 4'b0001);
    assign w_is_half = (i_req_byt_en == 4'b0011);
    assign w_is_word = (i_req_byt_en == 4'b1111);
    assign w_nbytes  = w_is_word ? 3'd4 : (w_is_half ? 3'd2 : 3'd1);

    // 33-bit end address so an access near 2^32 cannot wrap back into range
    assign w_end = {1'b0, i_req_addr} + {30'd0, w_nbytes};
    assign w_err = !(w_is_byte || w_is_half || w_is_word)
                 || (w_is_half && i_req_addr[0])
                 || (w_is_word && (i_req_addr[1:0] != 2'b00))
                 || (w_end > 33'(DEPTH));

    assign w_idx0 = i_req_addr[AW-1:0];
    assign w_idx1 = w_idx0 + IDX1;
    assign w_idx2 = w_idx0 + IDX2;
    assign w_idx3 = w_idx0 + IDX3;
    assign w_raw  = {r_mem[w_idx3], r_mem[w_idx2], r_mem[w_idx1], r_mem[w_idx0]};

    always_comb begin
        w_ext = w_raw;
        if (w_err) begin
            w_ext = 32'd0;
        end else if (w_is_byte) begin
            w_ext = {{24{i_req_sign_ext & w_raw[7]}}, w_raw[7:0]};
        end else if (w_is_half) begin
            w_ext = {{16{i_req_sign_ext & w_raw[15]}}, w_raw[15:0]};
        end
    end

    // Storage has no reset so contents survive a mid-operation reset
    always_ff @(posedge i_clk) begin
        if (w_accept && i_req_wr && !w_err) begin
            r_mem[w_idx0] <= i_req_wdata[7:0];
            if (!w_is_byte) begin
                r_mem[w_idx1] <= i_req_wdata[15:8];
            end
            if (w_is_word) begin
                r_mem[w_idx2] <= i_req_wdata[23:16];
                r_mem[w_idx3] <= i_req_wdata[31:24];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 4'd0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rsp_rdata <= i_req_wr ? 32'd0 : w_ext;
                r_rsp_err   <= w_err;
                r_wait_cnt  <= WAIT_LOAD;
            end else if ((r_state == S_WAIT) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = !i_rst;
                if (w_accept) begin
                    w_state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept    = i_req_valid && o_req_ready;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: instance 0 has no wait states, instance 1 has three.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_wr;
    logic [1:0]  req_sx;
    logic [1:0]  rsp_ready;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    wire  [1:0]  req_ready;
    wire  [1:0]  rsp_valid;
    wire  [1:0]  rsp_err;
    wire  [31:0] rsp_rdata [2];

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    dmem_responder #(.DEPTH(4096), .WAIT_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_req_wr(req_wr[0]), .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
        .i_req_byt_en(req_be[0]), .i_req_sign_ext(req_sx[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
        .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH(4096), .WAIT_CYCLES(3)) u_dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_req_wr(req_wr[1]), .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
        .i_req_byt_en(req_be[1]), .i_req_sign_ext(req_sx[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
        .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare whenever a response handshake is about to happen
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rsp_valid[d] && rsp_ready[d]) begin
                exp_t e;
                bit   have;
                have = 1'b0;
                e    = '0;
                if (d == 0 && q0.size() > 0) begin
                    e = q0.pop_front();
                    have = 1'b1;
                end else if (d == 1 && q1.size() > 0) begin
                    e = q1.pop_front();
                    have = 1'b1;
                end
                if (!have) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp dut%0d: got rdata %h with nothing expected", d, rsp_rdata[d]);
                end else begin
                    chk($sformatf("rsp_rdata dut%0d", d), rsp_rdata[d], e.rdata);
                    chk($sformatf("rsp_err dut%0d", d), {31'd0, rsp_err[d]}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic do_req(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input bit sx, input logic [31:0] exp_rd,
                          input bit exp_err, input int hold, input string name);
        int   n;
        int   lat;
        int   bad;
        exp_t e;
        tick();
        req_wr[d]    = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        req_sx[d]    = sx;
        req_valid[d] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            checks++;
            errors++;
            $display("FAIL %s accept: req_ready stuck at 0, required 1", name);
            req_valid[d] = 1'b0;
            return;
        end
        e.rdata = exp_rd;
        e.err   = exp_err;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        tick();
        // Scramble request fields after acceptance; they must be ignored
        req_valid[d] = 1'b0;
        req_wr[d]    = 1'b1;
        req_addr[d]  = 32'd0;
        req_wdata[d] = 32'hFFFF_FFFF;
        req_be[d]    = 4'hF;
        req_sx[d]    = ~sx;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid[d] && lat < 40);
        chk({name, " latency"}, 32'(lat), (d == 0) ? 32'd1 : 32'd4);
        if (!rsp_valid[d]) return;
        bad = 0;
        for (int k = 0; k < hold; k++) begin
            if (rsp_rdata[d] !== exp_rd || rsp_err[d] !== exp_err
                || req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b1) bad++;
            @(negedge clk);
        end
        if (hold > 0) chk({name, " hold_stable"}, 32'(bad), 32'd0);
        tick();
        rsp_ready[d] = 1'b1;
        tick();
        rsp_ready[d] = 1'b0;
        @(negedge clk);
        chk({name, " ready_after_hs"}, {31'd0, req_ready[d]}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        rst       = 1'b1;
        req_valid = '0;
        req_wr    = '0;
        req_sx    = '0;
        rsp_ready = '0;
        for (int d = 0; d < 2; d++) begin
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_be[d]    = '0;
        end
        repeat (3) tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset req_ready dut%0d", d), {31'd0, req_ready[d]}, 32'd0);
            chk($sformatf("reset rsp_valid dut%0d", d), {31'd0, rsp_valid[d]}, 32'd0);
            chk($sformatf("reset rsp_rdata dut%0d", d), rsp_rdata[d], 32'd0);
            chk($sformatf("reset rsp_err dut%0d", d), {31'd0, rsp_err[d]}, 32'd0);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset req_ready dut0", {31'd0, req_ready[0]}, 32'd1);
        chk("post_reset req_ready dut1", {31'd0, req_ready[1]}, 32'd1);

        // d  wr  addr          wdata          be     sx  exp_rdata      err hold name
        do_req(0, 1, 32'h10,       32'hDEADBEEF, 4'hF, 0, 32'h0,          0, 0, "SW 10");
        do_req(0, 0, 32'h10,       32'h0,        4'hF, 0, 32'hDEADBEEF,   0, 2, "LW 10");
        do_req(0, 0, 32'h13,       32'h0,        4'h1, 1, 32'hFFFFFFDE,   0, 0, "LB 13");
        do_req(0, 0, 32'h13,       32'h0,        4'h1, 0, 32'h000000DE,   0, 0, "LBU 13");
        do_req(0, 0, 32'h12,       32'h0,        4'h3, 1, 32'hFFFFDEAD,   0, 0, "LH 12");
        do_req(0, 0, 32'h10,       32'h0,        4'h3, 0, 32'h0000BEEF,   0, 0, "LHU 10");
        do_req(0, 0, 32'h11,       32'h0,        4'h1, 1, 32'hFFFFFFBE,   0, 0, "LB 11");
        do_req(0, 0, 32'h10,       32'h0,        4'hF, 1, 32'hDEADBEEF,   0, 0, "LW sx 10");
        do_req(0, 1, 32'h1F,       32'hFFFFFFA1, 4'h1, 0, 32'h0,          0, 0, "SB 1F");
        do_req(0, 1, 32'h24,       32'h000000B2, 4'h1, 0, 32'h0,          0, 0, "SB 24");
        do_req(0, 1, 32'h20,       32'h0,        4'hF, 0, 32'h0,          0, 0, "SW 20");
        do_req(0, 1, 32'h21,       32'h1234565A, 4'h1, 0, 32'h0,          0, 0, "SB 21");
        do_req(0, 1, 32'h22,       32'hABCD1234, 4'h3, 0, 32'h0,          0, 0, "SH 22");
        do_req(0, 0, 32'h20,       32'h0,        4'hF, 0, 32'h12345A00,   0, 0, "LW 20");
        do_req(0, 0, 32'h1F,       32'h0,        4'h1, 0, 32'h000000A1,   0, 0, "LBU 1F");
        do_req(0, 0, 32'h24,       32'h0,        4'h1, 0, 32'h000000B2,   0, 0, "LBU 24");
        do_req(0, 1, 32'h04,       32'h01020304, 4'hF, 0, 32'h0,          0, 0, "SW 04");
        do_req(0, 0, 32'h02,       32'h0,        4'hF, 0, 32'h0,          1, 0, "LW 02 err");
        do_req(0, 1, 32'h05,       32'hFFFF,     4'h3, 0, 32'h0,          1, 0, "SH 05 err");
        do_req(0, 0, 32'h04,       32'h0,        4'hF, 0, 32'h01020304,   0, 0, "LW 04");
        do_req(0, 0, 32'hFFE,      32'h0,        4'hF, 0, 32'h0,          1, 0, "LW FFE err");
        do_req(0, 0, 32'h10,       32'h0,        4'h5, 0, 32'h0,          1, 0, "LD be5 err");
        do_req(0, 1, 32'h10,       32'h0,        4'h5, 0, 32'h0,          1, 0, "ST be5 err");
        do_req(0, 0, 32'h13,       32'h0,        4'h0, 0, 32'h0,          1, 0, "LD be0 err");
        do_req(0, 0, 32'h10,       32'h0,        4'hF, 0, 32'hDEADBEEF,   0, 0, "LW 10 again");
        do_req(0, 1, 32'hFFC,      32'hCAFEF00D, 4'hF, 0, 32'h0,          0, 0, "SW FFC");
        do_req(0, 1, 32'hFFFFFFFC, 32'h99999999, 4'hF, 0, 32'h0,          1, 0, "SW top err");
        do_req(0, 0, 32'hFFC,      32'h0,        4'hF, 0, 32'hCAFEF00D,   0, 0, "LW FFC");
        do_req(0, 0, 32'hFFF,      32'h0,        4'h1, 0, 32'h000000CA,   0, 0, "LBU FFF");
        do_req(0, 0, 32'h1000,     32'h0,        4'h1, 0, 32'h0,          1, 0, "LB 1000 err");
        do_req(0, 0, 32'hFFF,      32'h0,        4'h3, 0, 32'h0,          1, 0, "LH FFF err");
        do_req(0, 0, 32'hFFE,      32'h0,        4'h3, 0, 32'h0000CAFE,   0, 0, "LHU FFE");

        do_req(1, 1, 32'h40,       32'h55667788, 4'hF, 0, 32'h0,          0, 0, "W3 SW 40");
        do_req(1, 0, 32'h40,       32'h0,        4'hF, 0, 32'h55667788,   0, 5, "W3 LW 40");
        do_req(1, 1, 32'h44,       32'h0,        4'hF, 0, 32'h0,          0, 0, "W3 SW 44");

        // Reset while the store sits in WAIT: store stays committed, response vanishes
        tick();
        req_wr[1] = 1'b1; req_addr[1] = 32'h40; req_wdata[1] = 32'h11223344;
        req_be[1] = 4'hF; req_sx[1] = 1'b0; req_valid[1] = 1'b1;
        @(negedge clk);
        chk("rst_mid accept ready", {31'd0, req_ready[1]}, 32'd1);
        tick();
        req_valid[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid ready in wait", {31'd0, req_ready[1]}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid ready after rst", {31'd0, req_ready[1]}, 32'd1);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid[1] !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("rst_mid no rsp_valid", 32'(bad), 32'd0);

        // Reset and a request in the same cycle: nothing is accepted
        tick();
        rst = 1'b1;
        req_wr[1] = 1'b1; req_addr[1] = 32'h44; req_wdata[1] = 32'hBAD0BAD0;
        req_be[1] = 4'hF; req_valid[1] = 1'b1;
        tick();
        rst = 1'b0;
        req_valid[1] = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b0) bad++;
        end
        chk("rst_vs_req no rsp_valid", 32'(bad), 32'd0);

        do_req(1, 0, 32'h40,       32'h0,        4'hF, 0, 32'h11223344,   0, 0, "W3 LW 40 post rst");
        do_req(1, 0, 32'h44,       32'h0,        4'hF, 0, 32'h0,          0, 0, "W3 LW 44 post rst");

        repeat (3) @(negedge clk);
        chk("queue0 drained", 32'(q0.size()), 32'd0);
        chk("queue1 drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
